sonar_capture_ctrl: RTL and testbench

Sequences one sonar ping/listen cycle on the 4-microphone I2S sample stream. On a software start it waits for the next frame_sync and fires a one-cycle transmit trigger. It then discards a programmable blanking interval and forwards exactly capture_len complete 4-mic sample sets downstream as one AXI-Stream packet ending in TLAST. It sits between the I2S interface (AXIS master, tuser = mic id) and the capture DMA.

---
 rtl/sonar_pkg.sv | 18 +
 rtl/sonar_cap_fifo.sv | 52 +++++
 rtl/sonar_capture_ctrl.sv | 131 +++++++++++++
 tb/tb_sonar_capture_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sonar_pkg.sv
// Shared types for the sonar ping/listen capture path: mic ids and the capture sequencer states.
// Pure declarations, no logic.
package sonar_pkg;

  localparam int NUM_MICS = 4;

  typedef enum logic [1:0] {
    LEFT_LOW   = 2'd0,
    LEFT_HIGH  = 2'd1,
    RIGHT_LOW  = 2'd2,
    RIGHT_HIGH = 2'd3
  } mic_enum;

  typedef enum logic [2:0] {
    IDLE, ARMED, PING, BLANK, ALIGN, CAPTURE, DRAIN, DONE
  } cap_state_t;

endpackage

// File: rtl/sonar_cap_fifo.sv
// Two-entry sample FIFO with an AXIS-style head; one cycle push-to-valid latency.
// A push while full is ignored (the caller counts it as a drop); flush empties it immediately.
module sonar_cap_fifo #(
  parameter int W = 35
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  output logic         full,
  output logic         empty,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_dat
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   cnt;
  logic         do_push;
  logic         do_pop;

  assign full    = (cnt == 2'd2);
  assign empty   = (cnt == 2'd0);
  assign out_vld = !empty;
  assign out_dat = mem[rd_ptr];
  assign do_pop  = out_vld && out_rdy;
  assign do_push = push && !full;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      mem    <= '{default: '0};
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/sonar_capture_ctrl.sv
// Sequences one ping/listen cycle: wait frame_sync, fire tx_trig, skip blank sets, forward capture sets as one packet.
// Input never stalls; output is one cycle behind acceptance, and samples arriving with the FIFO full are dropped.
module sonar_capture_ctrl #(
  parameter int NUM_MICS = sonar_pkg::NUM_MICS,
  parameter int DATA_W   = 32,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  blank_len,
  input  logic [CNT_W-1:0]  capture_len,
  input  logic              frame_sync,
  output logic              tx_trig,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic [1:0]        s_axis_tuser,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [1:0]        m_axis_tuser,
  output logic              m_axis_tlast
);
  import sonar_pkg::*;

  localparam logic [1:0] LAST_MIC = 2'(NUM_MICS - 1);

  cap_state_t       st;
  logic [CNT_W-1:0] blank_q;
  logic [CNT_W-1:0] cap_q;
  logic [CNT_W-1:0] blank_cnt;
  logic [CNT_W-1:0] set_cnt;

  logic fifo_full;
  logic fifo_empty;
  logic set_end;
  logic set_begin;
  logic push;
  logic push_last;
  logic drop;

  assign s_axis_tready = 1'b1;
  assign set_end   = s_axis_tvalid && (s_axis_tuser == LAST_MIC);
  assign set_begin = s_axis_tvalid && (s_axis_tuser == LEFT_LOW);
  assign push      = ((st == ALIGN) && set_begin) || ((st == CAPTURE) && s_axis_tvalid);
  assign push_last = (st == CAPTURE) && set_end && (set_cnt == cap_q - CNT_W'(1));
  assign drop      = push && fifo_full;

  sonar_cap_fifo #(.W(DATA_W + 3)) u_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .flush    (abort),
    .push     (push),
    .push_dat ({push_last, s_axis_tuser, s_axis_tdata}),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .out_vld  (m_axis_tvalid),
    .out_rdy  (m_axis_tready),
    .out_dat  ({m_axis_tlast, m_axis_tuser, m_axis_tdata})
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      st        <= IDLE;
      blank_q   <= '0;
      cap_q     <= '0;
      blank_cnt <= '0;
      set_cnt   <= '0;
      tx_trig   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
    end else if (abort) begin
      st        <= IDLE;
      blank_cnt <= '0;
      set_cnt   <= '0;
      tx_trig   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      tx_trig <= 1'b0;
      done    <= 1'b0;
      if (drop) overflow <= 1'b1;
      case (st)
        IDLE: if (start) begin
          blank_q   <= blank_len;
          cap_q     <= capture_len;
          blank_cnt <= '0;
          set_cnt   <= '0;
          overflow  <= 1'b0;
          busy      <= 1'b1;
          st        <= ARMED;
        end
        ARMED: if (frame_sync) begin
          tx_trig <= 1'b1;
          st      <= PING;
        end
        PING: begin
          if (cap_q == '0)        st <= DRAIN;
          else if (blank_q == '0) st <= ALIGN;
          else                    st <= BLANK;
        end
        BLANK: if (set_end) begin
          blank_cnt <= blank_cnt + CNT_W'(1);
          if (blank_cnt + CNT_W'(1) == blank_q) st <= ALIGN;
        end
        ALIGN: if (set_begin) st <= CAPTURE;
        // Counters advance even when the FIFO drops the sample, so packet length stays tied to time.
        CAPTURE: if (set_end) begin
          set_cnt <= set_cnt + CNT_W'(1);
          if (set_cnt == cap_q - CNT_W'(1)) st <= DRAIN;
        end
        DRAIN: if (fifo_empty) begin
          done <= 1'b1;
          st   <= DONE;
        end
        DONE: begin
          busy <= 1'b0;
          st   <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sonar_capture_ctrl.sv
// Directed bench for sonar_capture_ctrl: a free-running 4-mic sample stream, one task per scenario.
module tb_sonar_capture_ctrl;

  logic        clk = 1'b0;
  logic        rstn, start, abort, frame_sync;
  logic [15:0] blank_len, capture_len;
  logic        tx_trig, busy, done, overflow;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid, s_axis_tready;
  logic [1:0]  s_axis_tuser;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [1:0]  m_axis_tuser;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  u;
    logic        l;
  } beat_t;

  beat_t beats[$];
  int    tx_cnt   = 0;
  int    done_cnt = 0;

  always #5 clk = ~clk;

  sonar_capture_ctrl dut (
    .clk           (clk),
    .rstn          (rstn),
    .start         (start),
    .abort         (abort),
    .blank_len     (blank_len),
    .capture_len   (capture_len),
    .frame_sync    (frame_sync),
    .tx_trig       (tx_trig),
    .busy          (busy),
    .done          (done),
    .overflow      (overflow),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tuser  (s_axis_tuser),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast)
  );

  always @(posedge clk) begin
    if (m_axis_tvalid && m_axis_tready) beats.push_back({m_axis_tdata, m_axis_tuser, m_axis_tlast});
    if (tx_trig) tx_cnt++;
    if (done) done_cnt++;
  end

  // Every cycle the source presents the next sample; ids cycle 0,1,2,3.
  task automatic tick();
    @(posedge clk);
    #1;
    start        = 1'b0;
    abort        = 1'b0;
    frame_sync   = 1'b0;
    s_axis_tuser = s_axis_tuser + 2'd1;
    s_axis_tdata = s_axis_tdata + 32'd1;
  endtask

  // Starts a sequence (with a frame_sync that must be ignored), then syncs so the PING-cycle sample has ping_id.
  task automatic arm(input logic [15:0] bl, input logic [15:0] cl, input logic [1:0] ping_id,
                     output logic [31:0] ping_d, output bit early);
    int guard = 0;
    early       = 1'b0;
    blank_len   = bl;
    capture_len = cl;
    start       = 1'b1;
    frame_sync  = 1'b1;
    tick();
    tick();
    early = early | tx_trig;
    while (s_axis_tuser != ping_id - 2'd1 && guard < 8) begin
      tick();
      early = early | tx_trig;
      guard++;
    end
    frame_sync = 1'b1;
    tick();
    ping_d = s_axis_tdata;
  endtask

  task automatic run_to_done(input int max, output bit ok);
    int d0 = done_cnt;
    int n  = 0;
    while (done_cnt == d0 && n < max) begin
      tick();
      n++;
    end
    ok = (done_cnt != d0);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) tick();
    n_tests++;
    if ({tx_trig, busy, done, overflow, m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata} !== 40'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got tx%b busy%b done%b ovf%b vld%b last%b user%0d data%h, required all 0",
               tx_trig, busy, done, overflow, m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata);
    end
    n_tests++;
    if (s_axis_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_tready: got %b, required 1", s_axis_tready);
    end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_basic(input string tag);
    logic [31:0] p;
    bit          early, ok;
    int          b0 = beats.size();
    int          t0 = tx_cnt;
    int          d0 = done_cnt;
    int          err = 0;
    int          nb;
    m_axis_tready = 1'b1;
    arm(16'd2, 16'd3, 2'd3, p, early);
    n_tests++;
    if (early) begin
      n_fail++;
      $display("FAIL %s_early_ping: tx_trig seen before frame_sync, required none", tag);
    end
    n_tests++;
    if (tx_trig !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_ping: got tx_trig=%b busy=%b, required 1 1", tag, tx_trig, busy);
    end
    run_to_done(300, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_done_timeout: no done within 300 cycles", tag);
    end
    nb = beats.size() - b0;
    n_tests++;
    if (nb != 12) begin
      n_fail++;
      $display("FAIL %s_beat_count: got %0d, required 12", tag, nb);
    end
    for (int i = 0; i < nb && i < 12; i++)
      if (beats[b0+i] !== {p + 32'(9 + i), 2'(i % 4), (i == 11)}) err++;
    n_tests++;
    if (err != 0) begin
      n_fail++;
      $display("FAIL %s_beats: %0d beats differ from data p+9+i / tuser i%%4 / tlast on 12th, required 0", tag, err);
    end
    n_tests++;
    if (tx_cnt - t0 != 1 || done_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL %s_pulses: got tx %0d done %0d, required 1 1", tag, tx_cnt - t0, done_cnt - d0);
    end
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle: got busy=%b done=%b overflow=%b, required 0 0 0", tag, busy, done, overflow);
    end
  endtask

  task automatic test_align();
    logic [31:0] p;
    bit          early, ok;
    int          b0 = beats.size();
    int          err = 0;
    int          nb;
    arm(16'd0, 16'd2, 2'd1, p, early);
    repeat (4) tick();
    n_tests++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== p + 32'd3 || m_axis_tuser !== 2'd0) begin
      n_fail++;
      $display("FAIL align_first: got vld=%b data=%h user=%0d, required 1 %h 0",
               m_axis_tvalid, m_axis_tdata, m_axis_tuser, p + 32'd3);
    end
    run_to_done(300, ok);
    nb = beats.size() - b0;
    for (int i = 0; i < nb && i < 8; i++)
      if (beats[b0+i] !== {p + 32'(3 + i), 2'(i % 4), (i == 7)}) err++;
    n_tests++;
    if (!ok || nb != 8 || err != 0) begin
      n_fail++;
      $display("FAIL align_packet: got done=%b beats=%0d bad=%0d, required 1 8 0", ok, nb, err);
    end
  endtask

  task automatic test_zero_cap();
    logic [31:0] p;
    bit          early;
    int          b0 = beats.size();
    int          n = 0;
    arm(16'd5, 16'd0, 2'd0, p, early);
    n_tests++;
    if (tx_trig !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_cap_ping: got tx_trig=%b, required 1", tx_trig);
    end
    while (done !== 1'b1 && n < 6) begin
      tick();
      n++;
    end
    n_tests++;
    if (done !== 1'b1 || n > 3) begin
      n_fail++;
      $display("FAIL zero_cap_done: got done=%b after %0d cycles, required 1 within 3", done, n);
    end
    tick();
    n_tests++;
    if (busy !== 1'b0 || beats.size() != b0) begin
      n_fail++;
      $display("FAIL zero_cap_idle: got busy=%b beats=%0d, required 0 0", busy, beats.size() - b0);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] p;
    bit          early, ok;
    int          b0 = beats.size();
    int          err = 0;
    int          nb;
    int          off [7] = '{1, 2, 12, 13, 14, 15, 16};
    arm(16'd0, 16'd4, 2'd3, p, early);
    m_axis_tready = 1'b0;
    repeat (11) tick();
    n_tests++;
    if (overflow !== 1'b1 || m_axis_tvalid !== 1'b1 || m_axis_tdata !== p + 32'd1) begin
      n_fail++;
      $display("FAIL bp_stalled: got ovf=%b vld=%b data=%h, required 1 1 %h",
               overflow, m_axis_tvalid, m_axis_tdata, p + 32'd1);
    end
    m_axis_tready = 1'b1;
    run_to_done(300, ok);
    nb = beats.size() - b0;
    for (int i = 0; i < nb && i < 7; i++)
      if (beats[b0+i] !== {p + 32'(off[i]), 2'((off[i] + 3) % 4), (i == 6)}) err++;
    n_tests++;
    if (!ok || nb != 7 || err != 0) begin
      n_fail++;
      $display("FAIL bp_packet: got done=%b beats=%0d bad=%0d, required 1 7 0", ok, nb, err);
    end
    n_tests++;
    if (overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_sticky: got overflow=%b, required 1", overflow);
    end
  endtask

  task automatic test_abort();
    logic [31:0] p;
    bit          early;
    int          b0 = beats.size();
    int          guard = 0;
    int          sz, d0;
    arm(16'd0, 16'd4, 2'd3, p, early);
    n_tests++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_ovf_clear: got overflow=%b after start, required 0", overflow);
    end
    while (beats.size() - b0 < 5 && guard < 100) begin
      tick();
      guard++;
    end
    n_tests++;
    if (beats.size() - b0 < 5) begin
      n_fail++;
      $display("FAIL abort_wait: got %0d beats, required 5", beats.size() - b0);
    end
    abort = 1'b1;
    tick();
    n_tests++;
    if (m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_flush: got vld=%b busy=%b, required 0 0", m_axis_tvalid, busy);
    end
    sz = beats.size();
    d0 = done_cnt;
    repeat (12) tick();
    n_tests++;
    if (beats.size() != sz || done_cnt != d0) begin
      n_fail++;
      $display("FAIL abort_quiet: got %0d extra beats, %0d done pulses, required 0 0",
               beats.size() - sz, done_cnt - d0);
    end
    test_basic("post_abort");
  endtask

  task automatic test_reset_mid();
    logic [31:0] p;
    bit          early;
    arm(16'd0, 16'd4, 2'd3, p, early);
    repeat (6) tick();
    rstn = 1'b0;
    tick();
    n_tests++;
    if ({tx_trig, busy, done, overflow, m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata} !== 40'd0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got busy%b vld%b last%b user%0d data%h, required all 0",
               busy, m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata);
    end
    rstn = 1'b1;
    tick();
    test_basic("post_reset");
  endtask

  initial begin
    rstn          = 1'b0;
    start         = 1'b0;
    abort         = 1'b0;
    frame_sync    = 1'b0;
    blank_len     = 16'd0;
    capture_len   = 16'd0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 32'h0000_1000;
    s_axis_tuser  = 2'd0;
    m_axis_tready = 1'b1;
    test_reset();
    test_basic("basic");
    test_align();
    test_zero_cap();
    test_backpressure();
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
